// File: rtl/sec_uart_if.sv
// Host-side register bus of the secondary UART: decoded address, strobes,
// write/read data and interrupt handshake.
interface sec_uart_if;
  logic [2:0]  Addr;
  logic        En;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataWr;
  logic [15:0] DataRd;
  logic        IntReset;
  logic        IntReq;

  modport master (
    output Addr, En, Rd, Wr, DataWr, IntReset,
    input  DataRd, IntReq
  );

  modport slave (
    input  Addr, En, Rd, Wr, DataWr, IntReset,
    output DataRd, IntReq
  );
endinterface

// File: rtl/sec_uart.sv
// Secondary-side UART: RX path with a small FIFO, TX path with a one-byte
// holding register, 16-bit word register file on a decoded strobe bus.
module sec_uart #(
  parameter int unsigned FIFO_AW  = 3,
  parameter logic [15:0] DIV_INIT = 16'd207
) (
  input  logic       Clk,
  input  logic       Reset,
  sec_uart_if.slave  bus,
  input  logic       RxD,
  output logic       TxD
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t r_rx_state, w_rx_next;
  tx_state_t r_tx_state, w_tx_next;

  logic               r_rxs1, r_rxs2;
  logic               r_wr_d, r_rd_d;
  logic [15:0]        r_div;
  logic [2:0]         r_mask;
  logic               r_ovr, r_fe, r_irq, r_txd;
  logic [15:0]        r_rx_d, r_rx_cnt, r_tx_d, r_tx_cnt;
  logic [2:0]         r_rx_bit, r_tx_bit;
  logic [7:0]         r_rx_sh, r_tx_sh, r_hold;
  logic               r_hold_full;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_count;

  logic        w_rxs, w_wr_edge, w_rd_data, w_pop_req, w_pop, w_push;
  logic        w_empty, w_full, w_stop_smp, w_ovr_set, w_fe_set, w_err_clr;
  logic        w_rx_tick, w_tx_tick, w_take, w_txd, w_tx_idle;
  logic [15:0] w_div_eff, w_rdata, w_status;

  assign w_rxs      = r_rxs2;
  assign w_wr_edge  = bus.En & bus.Wr & ~r_wr_d;
  // Pop is keyed to the trailing edge of a DATA read so the head stays stable
  // for the whole access.
  assign w_rd_data  = bus.En & bus.Rd & (bus.Addr == 3'd0);
  assign w_pop_req  = r_rd_d & ~w_rd_data;
  assign w_empty    = (r_count == '0);
  assign w_full     = r_count[FIFO_AW];
  assign w_pop      = w_pop_req & ~w_empty;
  assign w_div_eff  = (r_div < 16'd3) ? 16'd3 : r_div;
  assign w_rx_tick  = (r_rx_cnt == '0);
  assign w_tx_tick  = (r_tx_cnt == '0);
  assign w_stop_smp = (r_rx_state == RX_STOP) & w_rx_tick;
  // A pop in the same cycle frees the slot before the push lands.
  assign w_push     = w_stop_smp & w_rxs & (~w_full | w_pop);
  assign w_ovr_set  = w_stop_smp & w_rxs & w_full & ~w_pop;
  assign w_fe_set   = w_stop_smp & ~w_rxs;
  assign w_err_clr  = bus.IntReset;
  assign w_take     = r_hold_full & ((r_tx_state == TX_IDLE) |
                                     ((r_tx_state == TX_STOP) & w_tx_tick));
  assign w_tx_idle  = (r_tx_state == TX_IDLE) & ~r_hold_full;
  assign w_status   = {4'd0, 4'(r_count), 2'b00, r_fe, r_ovr, w_tx_idle,
                       ~r_hold_full, w_full, ~w_empty};

  assign bus.DataRd = w_rdata;
  assign bus.IntReq = r_irq;
  assign TxD        = r_txd;

  // RxD synchroniser and bus strobe edge-detect history
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rxs1 <= 1'b1;
      r_rxs2 <= 1'b1;
      r_wr_d <= 1'b0;
      r_rd_d <= 1'b0;
    end else begin
      r_rxs1 <= RxD;
      r_rxs2 <= r_rxs1;
      r_wr_d <= bus.En & bus.Wr;
      r_rd_d <= w_rd_data;
    end
  end

  // Writable registers and sticky error flags (set wins over clear)
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_div  <= DIV_INIT;
      r_mask <= '0;
      r_ovr  <= 1'b0;
      r_fe   <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_edge && bus.Addr == 3'd2) r_div  <= bus.DataWr;
      if (w_wr_edge && bus.Addr == 3'd3) r_mask <= bus.DataWr[2:0];
      r_ovr <= w_ovr_set | (r_ovr & ~(w_err_clr |
               (w_wr_edge & (bus.Addr == 3'd1) & bus.DataWr[4])));
      r_fe  <= w_fe_set  | (r_fe  & ~(w_err_clr |
               (w_wr_edge & (bus.Addr == 3'd1) & bus.DataWr[5])));
      r_irq <= |(r_mask & {r_ovr | r_fe, ~r_hold_full, ~w_empty});
    end
  end

  // Combinational read mux
  always_comb begin
    w_rdata = '0;
    if (bus.En) begin
      unique case (bus.Addr)
        3'd0:    w_rdata = {8'h00, w_empty ? 8'h00 : r_mem[r_rp]};
        3'd1:    w_rdata = w_status;
        3'd2:    w_rdata = r_div;
        3'd3:    w_rdata = {13'd0, r_mask};
        default: w_rdata = '0;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge Clk) begin
    if (w_push) r_mem[r_wp] <= r_rx_sh;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // RX state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // RX next-state
  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE:  if (!w_rxs) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = w_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // RX bit timer, bit index and shift register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rx_d   <= DIV_INIT;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      unique case (r_rx_state)
        RX_IDLE: if (!w_rxs) begin
          r_rx_d   <= w_div_eff;
          r_rx_cnt <= w_div_eff >> 1;
        end
        RX_START: if (w_rx_tick) begin
          r_rx_cnt <= r_rx_d;
          r_rx_bit <= '0;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_DATA: if (w_rx_tick) begin
          r_rx_sh  <= {w_rxs, r_rx_sh[7:1]};
          r_rx_cnt <= r_rx_d;
          r_rx_bit <= r_rx_bit + 3'd1;
        end else r_rx_cnt <= r_rx_cnt - 16'd1;
        RX_STOP: if (!w_rx_tick) r_rx_cnt <= r_rx_cnt - 16'd1;
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // TX state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  // TX next-state and line level for the current bit
  always_comb begin
    w_tx_next = r_tx_state;
    w_txd     = 1'b1;
    unique case (r_tx_state)
      TX_IDLE:  if (r_hold_full) w_tx_next = TX_START;
      TX_START: begin
        w_txd = 1'b0;
        if (w_tx_tick) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_txd = r_tx_sh[r_tx_bit];
        if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
      end
      TX_STOP:  if (w_tx_tick) w_tx_next = r_hold_full ? TX_START : TX_IDLE;
      default:  w_tx_next = TX_IDLE;
    endcase
  end

  // TX holding register, bit timer, shifter and registered line driver
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_d      <= DIV_INIT;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_sh     <= '0;
      r_txd       <= 1'b1;
    end else begin
      r_txd <= w_txd;
      if (w_take) begin
        r_hold_full <= 1'b0;
      end else if (w_wr_edge && bus.Addr == 3'd0 && !r_hold_full) begin
        r_hold      <= bus.DataWr[7:0];
        r_hold_full <= 1'b1;
      end
      if (w_take) begin
        r_tx_d   <= w_div_eff;
        r_tx_cnt <= w_div_eff;
        r_tx_sh  <= r_hold;
        r_tx_bit <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        if (w_tx_tick) begin
          r_tx_cnt <= r_tx_d;
          if (r_tx_state == TX_DATA) r_tx_bit <= r_tx_bit + 3'd1;
        end else r_tx_cnt <= r_tx_cnt - 16'd1;
      end
    end
  end
endmodule
